// File: rtl/asi_usr_csr.sv
// asi_usr_csr: control/status register bank on the user-side SRAM-style port of the AXI slave.
// Ports: usr_clk/usr_reset_n (async low), usr_a/usr_ce/usr_d/usr_we access port, usr_q read data
// (SLV_WS-cycle latency, holds between reads), irq (registered level), timer_tick (match pulse).
// Optional timer (TCMP, TCNT, CTRL[0], ISTAT[0], timer_tick) is built only with ASI_CSR_TIMER_EN.
module asi_usr_csr #(
   parameter int          AXI_DW     = 128,
   parameter int          AXI_AW     = 40,
   parameter int          AXI_WSTRBW = AXI_DW/8,
   parameter int          SLV_WS     = 1,
   parameter logic [31:0] CSR_ID     = 32'hA51C_0001,
   parameter int          ADDR_LSB   = $clog2(AXI_DW/8)
) (
   input  logic                  usr_clk,
   input  logic                  usr_reset_n,
   input  logic [AXI_AW-1:0]     usr_a,
   input  logic                  usr_ce,
   input  logic [AXI_DW-1:0]     usr_d,
   input  logic [AXI_WSTRBW-1:0] usr_we,
   output logic [AXI_DW-1:0]     usr_q,
   output logic                  irq,
   output logic                  timer_tick
);

   // Byte-lane merge of a 32-bit register with the low write lanes.
   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int k = 0; k < 4; k++)
         if (be[k]) r[8*k +: 8] = d[8*k +: 8];
      return r;
   endfunction

   logic [2:0]  idx;
   logic        wr_acc;
   logic        rd_acc;
   logic        mapped;
   logic        unmapped_acc;
   logic [31:0] scratch;
   logic        ctrl_ie;
   logic        ctrl_te;
   logic        tmatch;
   logic [1:0]  istat;
   logic [1:0]  istat_set;
   logic [1:0]  istat_clr;
   logic [31:0] eaddr;
   logic [31:0] rd_mux;
   logic [31:0] q_dat;

   // Only the low address/data/strobe bits carry meaning; the rest are intentionally dropped.
   logic unused_ok;
   assign unused_ok = ^{usr_a, usr_d, usr_we};

   assign idx    = usr_a[ADDR_LSB+2:ADDR_LSB];
   assign wr_acc = usr_ce & (|usr_we);
   assign rd_acc = usr_ce & ~(|usr_we);

`ifdef ASI_CSR_TIMER_EN
   assign mapped = (idx != 3'd7);
`else
   assign mapped = (idx != 3'd7) && (idx != 3'd3) && (idx != 3'd4);
`endif
   assign unmapped_acc = usr_ce & ~mapped;

`ifdef ASI_CSR_TIMER_EN
   logic [31:0] tcmp;
   logic [31:0] tcnt;
   logic        wr_tcnt;

   assign wr_tcnt = wr_acc && (idx == 3'd4);
   // A counter load pre-empts both the increment and the match for that cycle.
   assign tmatch     = ctrl_te & (tcnt == tcmp) & ~wr_tcnt;
   assign timer_tick = tmatch;

   always_ff @(posedge usr_clk or negedge usr_reset_n) begin
      if (!usr_reset_n) begin
         ctrl_te <= 1'b0;
         tcmp    <= '0;
         tcnt    <= '0;
      end else begin
         if (wr_acc && idx == 3'd2 && usr_we[0]) ctrl_te <= usr_d[0];
         if (wr_acc && idx == 3'd3) tcmp <= merge(tcmp, usr_d[31:0], usr_we[3:0]);
         if (wr_tcnt)
            tcnt <= merge(tcnt, usr_d[31:0], usr_we[3:0]);
         else if (ctrl_te)
            tcnt <= tmatch ? 32'd0 : tcnt + 32'd1;
      end
   end
`else
   assign ctrl_te    = 1'b0;
   assign tmatch     = 1'b0;
   assign timer_tick = 1'b0;
`endif

   // Hardware sets are OR'd in after the W1C mask, so a same-cycle set wins.
   assign istat_set = {unmapped_acc, tmatch};
   assign istat_clr = (wr_acc && idx == 3'd5 && usr_we[0]) ? usr_d[1:0] : 2'b00;

   always_ff @(posedge usr_clk or negedge usr_reset_n) begin
      if (!usr_reset_n) begin
         scratch <= '0;
         ctrl_ie <= 1'b0;
         istat   <= '0;
         eaddr   <= '0;
         irq     <= 1'b0;
      end else begin
         if (wr_acc && idx == 3'd1) scratch <= merge(scratch, usr_d[31:0], usr_we[3:0]);
         if (wr_acc && idx == 3'd2 && usr_we[0]) ctrl_ie <= usr_d[1];
         istat <= (istat & ~istat_clr) | istat_set;
         // EADDR keeps the first offender until software clears ISTAT[1].
         if (unmapped_acc && !istat[1]) eaddr <= usr_a[31:0];
         irq <= ctrl_ie & (|istat);
      end
   end

   always_comb begin
      rd_mux = '0;
      case (idx)
         3'd0: rd_mux = CSR_ID;
         3'd1: rd_mux = scratch;
         3'd2: rd_mux = {30'd0, ctrl_ie, ctrl_te};
`ifdef ASI_CSR_TIMER_EN
         3'd3: rd_mux = tcmp;
         3'd4: rd_mux = tcnt;
`endif
         3'd5: rd_mux = {30'd0, istat};
         3'd6: rd_mux = eaddr;
         default: rd_mux = '0;
      endcase
   end

   // Read data is captured in the access cycle and carried with a valid bit so that
   // usr_q only changes when a read completes and holds otherwise.
   generate
      if (SLV_WS == 1) begin : g_ws1
         always_ff @(posedge usr_clk or negedge usr_reset_n) begin
            if (!usr_reset_n) q_dat <= '0;
            else if (rd_acc)  q_dat <= rd_mux;
         end
      end else begin : g_wsn
         logic [SLV_WS-2:0] pv;
         logic [31:0]       pd [SLV_WS-1];
         always_ff @(posedge usr_clk or negedge usr_reset_n) begin
            if (!usr_reset_n) begin
               pv    <= '0;
               q_dat <= '0;
               for (int i = 0; i < SLV_WS-1; i++) pd[i] <= '0;
            end else begin
               pv[0] <= rd_acc;
               pd[0] <= rd_mux;
               for (int i = 1; i < SLV_WS-1; i++) begin
                  pv[i] <= pv[i-1];
                  pd[i] <= pd[i-1];
               end
               if (pv[SLV_WS-2]) q_dat <= pd[SLV_WS-2];
            end
         end
      end
   endgenerate

   assign usr_q = AXI_DW'(q_dat);

endmodule

// File: tb/tb_asi_usr_csr.sv
module tb_asi_usr_csr;

   logic         usr_clk;
   logic         usr_reset_n;
   logic [39:0]  usr_a;
   logic         usr_ce;
   logic [127:0] usr_d;
   logic [15:0]  usr_we;
   logic [127:0] q1, q3;
   logic         irq1, irq3, tick1, tick3;

   int checks = 0;
   int errors = 0;

   localparam logic [127:0] ID = 128'hA51C_0001;

   asi_usr_csr #(.SLV_WS(1)) u1 (
      .usr_clk(usr_clk), .usr_reset_n(usr_reset_n), .usr_a(usr_a), .usr_ce(usr_ce),
      .usr_d(usr_d), .usr_we(usr_we), .usr_q(q1), .irq(irq1), .timer_tick(tick1));

   asi_usr_csr #(.SLV_WS(3)) u3 (
      .usr_clk(usr_clk), .usr_reset_n(usr_reset_n), .usr_a(usr_a), .usr_ce(usr_ce),
      .usr_d(usr_d), .usr_we(usr_we), .usr_q(q3), .irq(irq3), .timer_tick(tick3));

   initial usr_clk = 1'b0;
   always #5 usr_clk = ~usr_clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge usr_clk);
      #1;
   endtask

   task automatic idle();
      usr_ce = 1'b0;
      usr_we = '0;
      usr_a  = '0;
      usr_d  = '0;
   endtask

   task automatic wr(input logic [39:0] a, input logic [127:0] d, input logic [15:0] we);
      usr_a  = a;
      usr_d  = d;
      usr_we = we;
      usr_ce = 1'b1;
      cyc();
      idle();
   endtask

   task automatic rd(input logic [39:0] a);
      usr_a  = a;
      usr_we = '0;
      usr_ce = 1'b1;
      cyc();
      idle();
   endtask

   initial begin
      idle();
      usr_reset_n = 1'b0;
      repeat (3) @(posedge usr_clk);
      #1;
      chk("reset_q1", q1, 128'd0);
      chk("reset_q3", q3, 128'd0);
      chk("reset_irq", irq1, 1'b0);
      chk("reset_tick", tick3, 1'b0);
      usr_reset_n = 1'b1;
      cyc();

      // Test 1: ID read latency
      chk("id_before", q1, 128'd0);
      rd(40'h00);
      chk("id_ws1", q1, ID);
      chk("id_ws3_c1", q3, 128'd0);
      cyc();
      chk("id_ws3_c2", q3, 128'd0);
      cyc();
      chk("id_ws3_c3", q3, ID);
      chk("irq_idle", irq1, 1'b0);
      chk("tick_idle", tick1, 1'b0);

      // Test 2: byte-granular scratch write, back-to-back reads
      wr(40'h10, 128'h1234_5678, 16'h0003);
      rd(40'h10);
      chk("scratch_part", q1, 128'h5678);
      cyc(); cyc();
      chk("scratch_ws3", q3, 128'h5678);
      usr_ce = 1'b1; usr_we = '0; usr_a = 40'h00;
      cyc();
      chk("b2b_ws1_a", q1, ID);
      usr_a = 40'h10;
      cyc();
      idle();
      chk("b2b_ws1_b", q1, 128'h5678);
      chk("b2b_ws3_hold", q3, 128'h5678);
      cyc();
      chk("b2b_ws3_a", q3, ID);
      cyc();
      chk("b2b_ws3_b", q3, 128'h5678);

      // Write right after a read must not disturb the in-flight data; upper bits read 0
      usr_ce = 1'b1; usr_we = '0; usr_a = 40'h10;
      cyc();
      chk("war_ws1", q1, 128'h5678);
      usr_d = {96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 32'hAAAA_BBBB};
      usr_we = 16'hFFFF;
      cyc();
      idle();
      cyc();
      chk("war_ws3", q3, 128'h5678);
      rd(40'h10);
      chk("scratch_full", q1, 128'hAAAA_BBBB);

      // RO write ignored without error
      wr(40'h00, 128'hDEAD_BEEF, 16'h000F);
      rd(40'h00);
      chk("id_ro", q1, ID);
      rd(40'h50);
      chk("istat_ro_noerr", q1, 128'd0);

`ifdef ASI_CSR_TIMER_EN
      // Test 3/4: timer match, tick, ISTAT[0], irq, W1C vs set
      wr(40'h30, 128'd4, 16'h000F);
      wr(40'h20, 128'd3, 16'h000F);
      chk("tick_c0", tick1, 1'b0);
      cyc(); chk("tick_c1", tick1, 1'b0);
      cyc(); chk("tick_c2", tick1, 1'b0);
      cyc(); chk("tick_c3", tick1, 1'b0);
      cyc(); chk("tick_c4", tick1, 1'b1);
      chk("irq_c4", irq1, 1'b0);
      cyc(); chk("tick_c5", tick1, 1'b0);
      chk("irq_c5", irq1, 1'b0);
      cyc(); chk("irq_c6", irq1, 1'b1);
      rd(40'h40);
      chk("tcnt_c6", q1, 128'd1);
      wr(40'h50, 128'd1, 16'h0001);
      chk("irq_after_w1c", irq1, 1'b1);
      cyc();
      chk("irq_dropped", irq1, 1'b0);
      chk("tick_c9", tick1, 1'b1);
      wr(40'h50, 128'd1, 16'h0001);
      chk("irq_c10", irq1, 1'b0);
      cyc();
      chk("irq_set_wins", irq1, 1'b1);
      rd(40'h50);
      chk("istat_set_wins", q1, 128'd1);

      // Wrap and hold
      wr(40'h30, 128'h10, 16'h000F);
      wr(40'h40, 128'hFFFF_FFFF, 16'h000F);
      rd(40'h40);
      chk("tcnt_max", q1, 128'hFFFF_FFFF);
      rd(40'h40);
      chk("tcnt_wrap", q1, 128'd0);
      wr(40'h20, 128'd2, 16'h000F);
      rd(40'h40);
      chk("tcnt_hold_a", q1, 128'd2);
      chk("tick_off", tick1, 1'b0);
      rd(40'h40);
      chk("tcnt_hold_b", q1, 128'd2);
      rd(40'h20);
      chk("ctrl_rd", q1, 128'd2);
`else
      wr(40'h20, 128'hFFFF_FFFF, 16'h000F);
      rd(40'h20);
      chk("ctrl_rd", q1, 128'd2);
`endif

      // Test 5: unmapped accesses and EADDR capture
      wr(40'h20, 128'd2, 16'h000F);
      wr(40'h50, 128'd3, 16'h0001);
      cyc(); cyc();
      chk("irq_clear", irq1, 1'b0);
      rd(40'h70);
      chk("unmapped_rd", q1, 128'd0);
      chk("irq_lag", irq1, 1'b0);
      cyc();
      chk("irq_unmapped", irq3, 1'b1);
      wr(40'h170, 128'hFFFF, 16'h000F);
      rd(40'h50);
      chk("istat_err", q1, 128'd2);
      rd(40'h60);
      chk("eaddr_first", q1, 128'h70);
      wr(40'h50, 128'd2, 16'h0001);
      chk("irq_w1c_lag", irq1, 1'b1);
      cyc();
      chk("irq_w1c", irq1, 1'b0);
      rd(40'h50);
      chk("istat_w1c", q1, 128'd0);
      rd(40'hF0);
      chk("unmapped_rd2", q1, 128'd0);
      rd(40'h60);
      chk("eaddr_second", q1, 128'hF0);

`ifndef ASI_CSR_TIMER_EN
      // Test 6: timer registers absent
      wr(40'h50, 128'd2, 16'h0001);
      wr(40'h40, 128'd5, 16'h000F);
      rd(40'h50);
      chk("tcnt_wr_err", q1, 128'd2);
      rd(40'h40);
      chk("tcnt_rd_zero", q1, 128'd0);
      rd(40'h60);
      chk("eaddr_tcnt", q1, 128'h40);
      chk("tick_tied", tick1, 1'b0);
`endif

      // Reset during a 3-deep read burst
      usr_ce = 1'b1; usr_we = '0; usr_a = 40'h00;
      cyc();
      usr_a = 40'h10;
      cyc();
      usr_a = 40'h20;
      cyc();
      idle();
      usr_reset_n = 1'b0;
      #1;
      chk("rst_q1", q1, 128'd0);
      chk("rst_q3", q3, 128'd0);
      chk("rst_irq", irq1, 1'b0);
      repeat (2) @(posedge usr_clk);
      #1;
      usr_reset_n = 1'b1;
      repeat (4) cyc();
      chk("rst_late_q3", q3, 128'd0);
      chk("rst_late_q1", q1, 128'd0);
      rd(40'h10);
      chk("rst_scratch", q1, 128'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
